// File: rtl/mem_stage.sv
// Memory-access pipeline stage. It takes EX results, performs loads and
// stores over a req/ack data-memory port with variable latency, aligns and
// extends load data, and registers the outcome into the MEM/WB register
// that feeds the write-back unit.
//
// Handshake: while dmem_req is high, dmem_addr/we/be/wdata are held
// constant. The access completes in the cycle dmem_ack is seen high with
// dmem_req high. dmem_ack seen outside an access is ignored.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic [31:0] ex_pc_imm,
    input  logic [31:0] ex_imm,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_reg_in_sel,
    input  logic        ex_mem_reg,
    input  logic        ex_reg_wr,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_pc_imm,
    output logic [31:0] wb_imm,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_reg_in_sel,
    output logic        wb_mem_reg,
    output logic        wb_reg_wr
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // The wait counter counts ACCESS cycles without ack. The access is
    // aborted in the cycle that would be the MAX_WAIT-th such cycle, so the
    // counter itself never needs to hold MAX_WAIT.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  wait_cnt;

    // Instruction held for the duration of an access
    logic [31:0] h_addr;
    logic [2:0]  h_funct3;
    logic        h_we;
    logic [3:0]  h_be;
    logic [31:0] h_wdata;
    logic [31:0] h_pc_imm;
    logic [31:0] h_imm;
    logic [4:0]  h_rd;
    logic [1:0]  h_reg_in_sel;
    logic        h_mem_reg;
    logic        h_reg_wr;

    // Decode of the incoming EX/MEM slot
    logic        is_mem_op;
    logic        is_alu_op;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // FSM decisions
    logic        start;
    logic        done;
    logic        timeout;
    logic        err_nx;

    // Load alignment
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    // Classify the EX/MEM slot and compute store lanes from the address
    always_comb begin
        is_mem_op  = ex_valid & (ex_mem_rd | ex_mem_wr);
        is_alu_op  = ex_valid & ~ex_mem_rd & ~ex_mem_wr;
        misaligned = ((ex_funct3[1:0] == 2'b01) & ex_alu_out[0]) |
                     ((ex_funct3[1:0] == 2'b10) & (ex_alu_out[1:0] != 2'b00));
        be_calc    = 4'b1111;
        wdata_calc = ex_rs2_data;
        case (ex_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ex_alu_out[1:0];
                wdata_calc = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                be_calc    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{ex_rs2_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = ex_rs2_data;
            end
        endcase
    end

    // Next-state and stall logic. A misaligned op is dropped as a bubble
    // without stalling, so upstream advances to the next instruction at
    // once. A timed-out access releases the stall in its last request
    // cycle so the aborted instruction is not re-issued.
    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem_op) begin
                    if (misaligned) begin
                        err_nx = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        start     = 1'b1;
                        state_nx  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout  = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            if (state == ACCESS && !dmem_ack && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    // Capture the memory instruction when the access starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_addr       <= 32'd0;
            h_funct3     <= 3'd0;
            h_we         <= 1'b0;
            h_be         <= 4'd0;
            h_wdata      <= 32'd0;
            h_pc_imm     <= 32'd0;
            h_imm        <= 32'd0;
            h_rd         <= 5'd0;
            h_reg_in_sel <= 2'd0;
            h_mem_reg    <= 1'b0;
            h_reg_wr     <= 1'b0;
        end else if (start) begin
            h_addr       <= ex_alu_out;
            h_funct3     <= ex_funct3;
            h_we         <= ex_mem_wr;
            h_be         <= be_calc;
            h_wdata      <= wdata_calc;
            h_pc_imm     <= ex_pc_imm;
            h_imm        <= ex_imm;
            h_rd         <= ex_rd;
            h_reg_in_sel <= ex_reg_in_sel;
            h_mem_reg    <= ex_mem_reg;
            h_reg_wr     <= ex_reg_wr;
        end
    end

    // Memory port driven straight from the held registers so it is stable
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = h_we;
    assign dmem_addr  = {h_addr[31:2], 2'b00};
    assign dmem_be    = h_be;
    assign dmem_wdata = h_wdata;

    // Select the addressed byte/half of the read word and extend it
    always_comb begin
        rdata_shift = dmem_rdata >> {h_addr[1:0], 3'b000};
        case (h_funct3)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'd0, rdata_shift[7:0]};
            3'b101:  load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Error pulse, one cycle after a misaligned op or a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= err_nx;
        end
    end

    // MEM/WB register: an ALU op from IDLE, a completed access, or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_alu_out    <= 32'd0;
            wb_mem_data   <= 32'd0;
            wb_pc_imm     <= 32'd0;
            wb_imm        <= 32'd0;
            wb_rd         <= 5'd0;
            wb_reg_in_sel <= 2'd0;
            wb_mem_reg    <= 1'b0;
            wb_reg_wr     <= 1'b0;
        end else if (state == IDLE && is_alu_op) begin
            wb_alu_out    <= ex_alu_out;
            wb_mem_data   <= 32'd0;
            wb_pc_imm     <= ex_pc_imm;
            wb_imm        <= ex_imm;
            wb_rd         <= ex_rd;
            wb_reg_in_sel <= ex_reg_in_sel;
            wb_mem_reg    <= ex_mem_reg;
            wb_reg_wr     <= ex_reg_wr;
        end else if (done) begin
            wb_alu_out    <= h_addr;
            wb_mem_data   <= h_we ? 32'd0 : load_data;
            wb_pc_imm     <= h_pc_imm;
            wb_imm        <= h_imm;
            wb_rd         <= h_rd;
            wb_reg_in_sel <= h_reg_in_sel;
            wb_mem_reg    <= h_mem_reg;
            wb_reg_wr     <= h_reg_wr;
        end else begin
            wb_reg_wr     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed loads, stores, ALU ops, misaligned ops,
// a bus timeout and a reset during an access.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_pc_imm;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_reg_in_sel;
    logic        ex_mem_reg;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_err;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_pc_imm;
    logic [31:0] wb_imm;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_reg_in_sel;
    logic        wb_mem_reg;
    logic        wb_reg_wr;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
        .ex_pc_imm(ex_pc_imm), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_reg_in_sel(ex_reg_in_sel), .ex_mem_reg(ex_mem_reg),
        .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_funct3(ex_funct3), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .mem_err(mem_err), .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data),
        .wb_pc_imm(wb_pc_imm), .wb_imm(wb_imm), .wb_rd(wb_rd),
        .wb_reg_in_sel(wb_reg_in_sel), .wb_mem_reg(wb_mem_reg),
        .wb_reg_wr(wb_reg_wr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;
    int err_seen = 0;

    // Expected MEM/WB writes: {chk_mem, alu, mem_data, pc_imm, imm, rd, sel, mem_reg}
    logic [136:0] wb_q[$];
    // Expected bus completions: {addr, we, be, wdata, chk_wr}
    logic [69:0]  bus_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: place one instruction in the EX/MEM slot
    task automatic drive(input logic valid, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rdi,
                         input logic [1:0] sel, input logic mreg, input logic rwr);
        ex_valid      = valid;
        ex_mem_rd     = rd;
        ex_mem_wr     = wr;
        ex_funct3     = f3;
        ex_alu_out    = alu;
        ex_rs2_data   = rs2;
        ex_rd         = rdi;
        ex_reg_in_sel = sel;
        ex_mem_reg    = mreg;
        ex_reg_wr     = rwr;
        ex_pc_imm     = alu + 32'h1000;
        ex_imm        = ~alu;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        dmem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rdi, input logic rwr);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, alu, 32'h0, rdi, 2'b00, 1'b0, rwr);
        dmem_ack = 1'b0;
        if (rwr) wb_q.push_back({1'b0, alu, 32'd0, alu + 32'h1000, ~alu, rdi, 2'b00, 1'b0});
        @(negedge clk);
        check("alu_stall", {31'd0, mem_stall}, 32'd0);
    endtask

    // Aligned load or store with a given number of wait cycles before ack
    task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input int waits, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic [4:0] rdi);
        int stall_cnt;
        logic is_st;
        is_st = wr;
        @(posedge clk); #1;
        drive(1'b1, rd, wr, f3, addr, rs2, rdi, 2'b01, ~is_st, ~is_st);
        dmem_ack = 1'b0;
        bus_q.push_back({addr & 32'hFFFF_FFFC, is_st, exp_be, exp_wdata, is_st});
        if (!is_st) wb_q.push_back({1'b1, addr, exp_data, addr + 32'h1000, ~addr, rdi, 2'b01, 1'b1});
        stall_cnt = 0;
        @(negedge clk);
        if (mem_stall) stall_cnt++;
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? rdata : $urandom;
            @(negedge clk);
            if (mem_stall) stall_cnt++;
            check("mem_req_held", {31'd0, dmem_req}, 32'd1);
        end
        check("mem_stall_cycles", stall_cnt, waits + 1);
    endtask

    // Misaligned op followed immediately by an ALU op
    task automatic misaligned_op(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] next_alu,
                                 input logic [4:0] next_rd);
        @(posedge clk); #1;
        drive(1'b1, rd, wr, f3, addr, 32'h1111_2222, 5'd3, 2'b01, rd, rd);
        dmem_ack = 1'b0;
        exp_err++;
        @(negedge clk);
        check("misal_no_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, next_alu, 32'h0, next_rd, 2'b00, 1'b0, 1'b1);
        wb_q.push_back({1'b0, next_alu, 32'd0, next_alu + 32'h1000, ~next_alu, next_rd, 2'b00, 1'b0});
        @(negedge clk);
        check("misal_err_pulse", {31'd0, mem_err}, 32'd1);
        check("misal_bubble", {31'd0, wb_reg_wr}, 32'd0);
        check("misal_next_no_stall", {31'd0, mem_stall}, 32'd0);
    endtask

    // LHU that never gets an ack
    task automatic timeout_op();
        int req_cnt;
        logic prev_stall;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 5'd12, 2'b01, 1'b1, 1'b1);
        dmem_ack = 1'b0;
        exp_err++;
        @(negedge clk);
        prev_stall = mem_stall;
        req_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!prev_stall) drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0);
            @(negedge clk);
            prev_stall = mem_stall;
            if (!dmem_req) break;
            req_cnt++;
            if (req_cnt == 15) check("timeout_stall_release", {31'd0, mem_stall}, 32'd0);
        end
        check("timeout_req_cycles", req_cnt, 15);
        check("timeout_err_pulse", {31'd0, mem_err}, 32'd1);
        check("timeout_bubble", {31'd0, wb_reg_wr}, 32'd0);
        idle_cycle();
        check("timeout_err_one_cycle", {31'd0, mem_err}, 32'd0);
    endtask

    // Reset asserted in the middle of an access, then a late ack
    task automatic reset_mid_access();
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd4, 2'b01, 1'b1, 1'b1);
        dmem_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("rst_req_before", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_drop", {31'd0, dmem_req}, 32'd0);
        check("rst_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
        check("rst_wb_alu", wb_alu_out, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_0001;
        @(negedge clk);
        check("late_ack_no_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("late_ack_no_wb", {31'd0, wb_reg_wr}, 32'd0);
        dmem_ack = 1'b0;
    endtask

    // Scoreboard monitor: compares every MEM/WB write and every bus completion
    always @(negedge clk) begin
        logic [136:0] we_;
        logic [69:0]  be_;
        if (mem_err) err_seen++;
        if (rst_n && wb_reg_wr) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected_write", {27'd0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
                we_ = wb_q.pop_front();
                check("wb_alu_out", wb_alu_out, we_[135:104]);
                if (we_[136]) check("wb_mem_data", wb_mem_data, we_[103:72]);
                check("wb_pc_imm", wb_pc_imm, we_[71:40]);
                check("wb_imm", wb_imm, we_[39:8]);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, we_[7:3]});
                check("wb_reg_in_sel", {30'd0, wb_reg_in_sel}, {30'd0, we_[2:1]});
                check("wb_mem_reg", {31'd0, wb_mem_reg}, {31'd0, we_[0]});
            end
        end
        if (rst_n && dmem_req && dmem_ack) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", dmem_addr, 32'hFFFF_FFFF);
            end else begin
                be_ = bus_q.pop_front();
                check("dmem_addr", dmem_addr, be_[69:38]);
                check("dmem_we", {31'd0, dmem_we}, {31'd0, be_[37]});
                if (be_[0]) begin
                    check("dmem_be", {28'd0, dmem_be}, {28'd0, be_[36:33]});
                    check("dmem_wdata", dmem_wdata, be_[32:1]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_wb_alu", wb_alu_out, 32'd0);
        check("reset_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
        check("reset_req", {31'd0, dmem_req}, 32'd0);
        check("reset_err", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        alu_op(32'h1234, 5'd5, 1'b1);
        alu_op(32'h0BAD_F00D, 5'd6, 1'b1);
        alu_op(32'h7777, 5'd8, 1'b0);
        // LB 0x103, 3 wait cycles
        mem_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 3, 32'h80FF_FF11, 4'h0, 32'h0, 32'hFFFF_FF80, 5'd7);
        // SH 0x202, immediate ack
        mem_op(1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_5678, 0, 32'h0, 4'b1100, 32'h5678_5678, 32'h0, 5'd0);
        // LH 0x42 upper half, sign-extended
        mem_op(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 0, 32'h8001_7FFF, 4'h0, 32'h0, 32'hFFFF_8001, 5'd10);
        // LHU 0x46 upper half, zero-extended
        mem_op(1'b1, 1'b0, 3'b101, 32'h46, 32'h0, 2, 32'h8001_7FFF, 4'h0, 32'h0, 32'h0000_8001, 5'd11);
        // LBU 0x41 byte 1
        mem_op(1'b1, 1'b0, 3'b100, 32'h41, 32'h0, 1, 32'h1234_F678, 4'h0, 32'h0, 32'h0000_00F6, 5'd13);
        // LB 0x100 positive byte
        mem_op(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 0, 32'hAABB_CC7F, 4'h0, 32'h0, 32'h0000_007F, 5'd14);
        // LW 0x44
        mem_op(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 1, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'hDEAD_BEEF, 5'd15);
        // SB 0x301
        mem_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h1234_56A5, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 5'd0);
        // SW 0x304, 2 wait cycles
        mem_op(1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFE_F00D, 2, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 5'd0);
        // SH 0x200 lower half
        mem_op(1'b0, 1'b1, 3'b001, 32'h200, 32'h0000_BEEF, 0, 32'h0, 4'b0011, 32'hBEEF_BEEF, 32'h0, 5'd0);
        // Both load and store set: treated as a store
        mem_op(1'b1, 1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, 32'h0, 4'b1111, 32'h1122_3344, 32'h0, 5'd0);

        misaligned_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h55AA, 5'd9);
        misaligned_op(1'b0, 1'b1, 3'b001, 32'h203, 32'h6600, 5'd16);
        idle_cycle();

        // Invalid slot with mem_rd set: no request, no stall
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd2, 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        check("invalid_no_stall", {31'd0, mem_stall}, 32'd0);
        idle_cycle();
        check("invalid_no_req", {31'd0, dmem_req}, 32'd0);

        // Stray ack while idle
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        @(negedge clk);
        check("stray_ack_no_req", {31'd0, dmem_req}, 32'd0);
        idle_cycle();

        timeout_op();
        alu_op(32'h4242, 5'd17, 1'b1);
        reset_mid_access();
        alu_op(32'h9999, 5'd18, 1'b1);
        repeat (3) idle_cycle();

        check("wb_queue_empty", wb_q.size(), 32'd0);
        check("bus_queue_empty", bus_q.size(), 32'd0);
        check("err_pulse_count", err_seen, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
